// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte producers.
// It grants one byte at a time, then waits for the transmitter's done pulse or a watchdog expiry.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 1000
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Busy,
  output logic                 o_Timeout,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 tx_dv_q, tx_dv_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 timeout_q, timeout_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     cand;

  // Rotating search starting at ptr; the first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && i_Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          tx_dv_d          = 1'b1;
          tx_byte_d        = i_Req_Byte[{win_idx, 3'b000} +: 8];
          cnt_d            = '0;
          ptr_d            = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
          state_d          = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Done wins over a simultaneous expiry, so no timeout is reported then.
        if (i_Tx_Done) begin
          state_d = GAP;
        end else if (cnt_q >= CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_Busy    = (state_q != IDLE);
  assign o_Grant   = grant_q;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;
  assign o_Timeout = timeout_q;

endmodule
